packet_serializer: RTL and testbench

PACKET_SERIALIZER -- requirements
Module: packet_serializer

---
 rtl/packet_serializer.sv | 111 +++++++++++
 tb/tb_packet_serializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/packet_serializer.sv
// FIFO-fed serializer: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Define SERIALIZER_PARITY_EN to insert the parity bit (11-bit frames instead of 10).
module packet_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic [7:0] i_packet,
  input  logic       i_empty,
  input  logic       i_wn,
  output logic       o_rn,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
`ifdef SERIALIZER_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd5
  } state_t;

  localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);

  state_t     state;
  logic [7:0] shreg;
  logic [7:0] timer;
  logic [2:0] idx;
  logic       bit_end;
`ifdef SERIALIZER_PARITY_EN
  logic       par;
`endif

  // Read is gated by reset so the FIFO never sees a strobe while we are held.
  assign o_rn    = (state == IDLE) & i_enable & ~i_empty & ~i_wn & i_reset_n;
  assign o_busy  = (state != IDLE);
  assign bit_end = (timer == 8'd0);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      o_tx    <= 1'b1;
      o_done  <= 1'b0;
      o_count <= 8'd0;
      shreg   <= 8'd0;
      timer   <= 8'd0;
      idx     <= 3'd0;
`ifdef SERIALIZER_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      if (state != IDLE && state != WAIT)
        timer <= bit_end ? RELOAD : timer - 8'd1;
      case (state)
        IDLE: if (o_rn) state <= WAIT;
        WAIT: begin
          // FIFO data is valid now, one cycle after the read strobe.
          shreg <= i_packet;
`ifdef SERIALIZER_PARITY_EN
          par   <= ^i_packet;
`endif
          o_tx  <= 1'b0;
          timer <= RELOAD;
          state <= START;
        end
        START: if (bit_end) begin
          o_tx  <= shreg[0];
          shreg <= {1'b0, shreg[7:1]};
          idx   <= 3'd0;
          state <= DATA;
        end
        DATA: if (bit_end) begin
          if (idx == 3'd7) begin
`ifdef SERIALIZER_PARITY_EN
            o_tx  <= par;
            state <= PARITY;
`else
            o_tx  <= 1'b1;
            state <= STOP;
`endif
          end else begin
            o_tx  <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
            idx   <= idx + 3'd1;
          end
        end
`ifdef SERIALIZER_PARITY_EN
        PARITY: if (bit_end) begin
          o_tx  <= 1'b1;
          state <= STOP;
        end
`endif
        STOP: if (bit_end) begin
          state   <= IDLE;
          o_done  <= 1'b1;
          o_count <= o_count + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_serializer.sv
// Bench for packet_serializer: frame-level reference model, per-cycle compare, directed literal frames.
`timescale 1ns/1ps
module tb_packet_serializer;
  localparam int CPB = 4;
`ifdef SERIALIZER_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FLEN  = NB * CPB;
  localparam int FRAME = 1 + FLEN;   // WAIT cycle plus the serial bits

  logic       clk = 1'b0, rst_n = 1'b1, en = 1'b0, empty = 1'b1, wn = 1'b0;
  logic [7:0] pkt = 8'd0;
  logic       rn, tx, busy, done;
  logic [7:0] count;
  int         vectors = 0, errors = 0;

  packet_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_packet(pkt),
    .i_empty(empty), .i_wn(wn), .o_rn(rn), .o_tx(tx), .o_busy(busy),
    .o_done(done), .o_count(count)
  );

  always #5 clk = ~clk;

  // Model: m_t = cycles into the current frame (0 = idle, 1 = wait, 2.. = serial bits).
  int         m_t = 0;
  logic [7:0] m_pkt = 8'd0, m_cnt = 8'd0;
  logic       m_done = 1'b0, m_rn, m_txe;

  function automatic logic frame_bit(input int b, input logic [7:0] d);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[3'(b - 1)];
`ifdef SERIALIZER_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  assign m_rn = (m_t == 0) && en && !empty && !wn && rst_n;
  always_comb begin
    m_txe = 1'b1;
    if (m_t >= 2) m_txe = frame_bit((m_t - 2) / CPB, m_pkt);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_pkt <= 8'd0; m_cnt <= 8'd0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_t == 0) begin
        if (m_rn) m_t <= 1;
      end else if (m_t == 1) begin
        m_pkt <= pkt;
        m_t   <= 2;
      end else if (m_t == FRAME) begin
        m_t    <= 0;
        m_done <= 1'b1;
        m_cnt  <= m_cnt + 8'd1;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("o_tx", tx, m_txe);
    chk("o_rn", rn, m_rn);
    chk("o_busy", busy, m_t != 0);
    chk("o_done", done, m_done);
    chk("o_count", count, m_cnt);
  end

  initial begin
    bit   exp_a5 [NB];
    bit   exp_00 [NB];
    bit   exp_ff [NB];
    int   bad, dones;
    logic exp_bit;
`ifdef SERIALIZER_PARITY_EN
    exp_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    exp_00 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    exp_ff = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
`else
    exp_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    exp_00 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    exp_ff = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Empty FIFO: no strobe, line idle, not busy.
    en = 1'b1; empty = 1'b1; bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (rn !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    chk("empty_idle", bad, 0);

    // Upstream write holds off the read for 5 cycles, then exactly one strobe.
    @(posedge clk); #2;
    empty = 1'b0; wn = 1'b1; pkt = 8'hA5; bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (rn !== 1'b0) bad++;
    end
    chk("wn_blocks_rn", bad, 0);
    @(posedge clk); #2 wn = 1'b0;
    @(negedge clk); chk("rn_after_wn", rn, 1);
    @(posedge clk); #2 en = 1'b0;
    @(negedge clk); chk("rn_single", rn, 0);
    for (int i = 0; i < FLEN; i++) begin
      @(negedge clk);
      if (i == 0) pkt = 8'h3C;
      chk("a5_tx", tx, exp_a5[i / CPB]);
      chk("a5_model", m_txe, exp_a5[i / CPB]);
    end
    @(negedge clk); chk("a5_done", done, 1); chk("a5_count", count, 1);
    chk("a5_model_cnt", m_cnt, 1);
    @(negedge clk); chk("a5_done_once", done, 0);

    // Reset during data bit 3 (A5 bit 3 is 0, so the line visibly snaps high).
    @(posedge clk); #2 en = 1'b1; pkt = 8'hA5;
    repeat (19) @(posedge clk);
    #1 chk("bit3_pre_tx", tx, 0); chk("bit3_pre_count", count, 1);
    rst_n = 1'b0;
    #1 chk("rst_tx", tx, 1); chk("rst_count", count, 0);
    chk("rst_busy", busy, 0); chk("rst_rn", rn, 0); chk("rst_done", done, 0);
    @(posedge clk); #2;

    // Release into back-to-back 0x00 then 0xFF.
    pkt = 8'h00; rst_n = 1'b1;
    @(negedge clk); chk("rn_first_after_rst", rn, 1);
    @(negedge clk); chk("wait_tx", tx, 1);
    for (int i = 0; i < 2 * FLEN + 2; i++) begin
      @(negedge clk);
      if (i == 0) pkt = 8'hFF;
      if (i == FLEN + 1) en = 1'b0;
      if (i < FLEN) exp_bit = exp_00[i / CPB];
      else if (i < FLEN + 2) exp_bit = 1'b1;
      else exp_bit = exp_ff[(i - FLEN - 2) / CPB];
      chk("b2b_tx", tx, exp_bit);
    end
    @(negedge clk); chk("b2b_done", done, 1); chk("b2b_count", count, 2);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      en    = ($urandom_range(0, 9) != 0);
      empty = ($urandom_range(0, 3) == 0);
      wn    = ($urandom_range(0, 4) == 0);
      pkt   = 8'($urandom);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
    end

    // Counter wrap: 256 continuous frames from reset.
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1; en = 1'b1; empty = 1'b0; wn = 1'b0;
    dones = 0;
    for (int c = 0; c < 256 * (FLEN + 2) + 100; c++) begin
      @(negedge clk);
      pkt = 8'($urandom);
      if (done) begin
        dones++;
        if (dones == 255) chk("count_255", count, 255);
        if (dones == 256) break;
      end
    end
    chk("wrap_frames", dones, 256);
    chk("count_wrap", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
